// File: rtl/serial_add_ctrl_if.sv
// Bus bundle for the bit-serial adder: operand/start request in,
// busy/done status and the registered result out.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start_in;
    logic [WIDTH-1:0] A_in;
    logic [WIDTH-1:0] B_in;
    logic             C_in;
    logic             busy_out;
    logic             done_out;
    logic [WIDTH-1:0] S_out;
    logic             C_out;

    modport master (
        output start_in, A_in, B_in, C_in,
        input  busy_out, done_out, S_out, C_out
    );

    modport slave (
        input  start_in, A_in, B_in, C_in,
        output busy_out, done_out, S_out, C_out
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds A + B + Cin one bit per clock, LSB
// first, through a single full-adder cell.
//
// state | meaning
// IDLE  | waiting for start_in; result registers hold the last sum
// RUN   | one operand bit pair added per clock
// DONE  | one-cycle done pulse, result final

module serial_add_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk_in,
    input  logic               rst_in,
    serial_add_ctrl_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               cy_q, cy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               co_q, co_d;

    logic               fa_sum;
    logic               fa_cout;

    serial_add_fa u_fa (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .c_i (cy_q),
        .s_o (fa_sum),
        .c_o (fa_cout)
    );

    // Next-state and datapath update; operands are only sampled on the
    // IDLE->RUN edge so later changes on the bus cannot disturb the sum.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cy_d    = cy_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        co_d    = co_q;
        case (state_q)
            IDLE: begin
                if (bus.start_in) begin
                    state_d = RUN;
                    a_d     = bus.A_in;
                    b_d     = bus.B_in;
                    cy_d    = bus.C_in;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                s_d  = {fa_sum, s_q[WIDTH-1:1]};
                cy_d = fa_cout;
                a_d  = a_q >> 1;
                b_d  = b_q >> 1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    co_d    = fa_cout;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cy_q    <= cy_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            co_q    <= co_d;
        end
    end

    assign bus.busy_out = (state_q != IDLE);
    assign bus.done_out = (state_q == DONE);
    assign bus.S_out    = s_q;
    assign bus.C_out    = co_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: a cycle-count model decides when a
// start is accepted and pushes the arithmetic sum; a negedge monitor pops
// and compares on every done pulse and checks busy/done timing and hold.
module tb_serial_add_ctrl;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(WIDTH)) bus();

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [WIDTH:0] exp_q[$];
    int             m_cnt    = 0;
    logic [WIDTH:0] m_cur    = '0;
    logic [WIDTH:0] last_res = '0;
    bit             m_valid  = 1'b0;
    int             n_accept = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, expv, $time);
        end
    endtask

    // Reference model: an accepted start makes the block busy for WIDTH+1
    // cycles (the last of which is the done cycle); starts are only taken
    // when not busy, and reset wipes any pending result.
    always @(posedge clk) begin
        if (rst) begin
            m_cnt    = 0;
            exp_q.delete();
            last_res = '0;
            m_valid  = 1'b1;
        end else if (m_cnt == 0) begin
            if (bus.start_in) begin
                m_cur = {1'b0, bus.A_in};
                m_cur = m_cur + {1'b0, bus.B_in} + {{WIDTH{1'b0}}, bus.C_in};
                exp_q.push_back(m_cur);
                m_cnt = WIDTH + 1;
                n_accept++;
            end
        end else begin
            m_cnt--;
            if (m_cnt == 0) last_res = m_cur;
        end
    end

    // Monitor.
    always @(negedge clk) begin
        logic [WIDTH:0] e;
        if (m_valid) begin
            check("busy", {63'd0, bus.busy_out}, {63'd0, (m_cnt != 0)});
            check("done_timing", {63'd0, bus.done_out}, {63'd0, (m_cnt == 1)});
            if (bus.done_out) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done_out=1 expected no pending op at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("sum", 64'({bus.C_out, bus.S_out}), 64'(e));
                end
            end
            if (m_cnt == 0)
                check("hold", 64'({bus.C_out, bus.S_out}), 64'(last_res));
        end
    end

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        bus.A_in     = a;
        bus.B_in     = b;
        bus.C_in     = c;
        bus.start_in = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b0;
        repeat (WIDTH + 3) @(negedge clk);
    endtask

    initial begin
        int base;
        int cyc;
        bus.start_in = 1'b0;
        bus.A_in     = '0;
        bus.B_in     = '0;
        bus.C_in     = 1'b0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        issue(8'h5A, 8'h33, 1'b0);
        issue(8'hFF, 8'h01, 1'b0);
        issue(8'hFF, 8'hFF, 1'b1);

        // Operand changes and extra starts during RUN and DONE are ignored.
        bus.A_in = 8'h10; bus.B_in = 8'h20; bus.C_in = 1'b0;
        bus.start_in = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b0;
        bus.A_in = WIDTH'($urandom); bus.B_in = WIDTH'($urandom); bus.C_in = 1'b1;
        repeat (2) @(negedge clk);
        bus.start_in = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b0;
        bus.A_in = WIDTH'($urandom); bus.B_in = WIDTH'($urandom);
        repeat (5) @(negedge clk);
        bus.start_in = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b0;
        repeat (WIDTH + 3) @(negedge clk);

        // Reset in the middle of RUN aborts without a done pulse.
        bus.A_in = 8'hC3; bus.B_in = 8'h5E; bus.C_in = 1'b1;
        bus.start_in = 1'b1;
        @(negedge clk);
        bus.start_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        issue(8'h01, 8'h01, 1'b0);

        // Start held high: back-to-back operations.
        bus.A_in = 8'h80; bus.B_in = 8'h80; bus.C_in = 1'b0;
        bus.start_in = 1'b1;
        repeat (40) @(negedge clk);
        bus.start_in = 1'b0;
        repeat (WIDTH + 4) @(negedge clk);

        // Randomized operations with random start activity.
        base = n_accept;
        cyc  = 0;
        while ((n_accept - base) < 1000 && cyc < 40000) begin
            bus.start_in = 1'($urandom_range(0, 1));
            bus.A_in     = WIDTH'($urandom);
            bus.B_in     = WIDTH'($urandom);
            bus.C_in     = 1'($urandom);
            @(negedge clk);
            cyc++;
        end
        bus.start_in = 1'b0;
        repeat (WIDTH + 4) @(negedge clk);
        check("random_ops", 64'(n_accept - base), 64'd1000);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
